// File: rtl/insn_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package insn_pkg;

  // Instruction formats; encodings 6 and 7 are illegal on fmt_i.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Raw decoded fields as held in the first pipeline stage. fmt is kept as
  // plain bits so illegal encodings survive into the packer.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } s1_fields_t;

endpackage

// File: rtl/insn_pack.sv
// Combinational packer: decoded fields -> 32-bit RV32I word plus an
// "immediate not representable / format illegal" flag.
module insn_pack
  import insn_pkg::*;
(
  input  s1_fields_t  fields,
  output logic [31:0] insn,
  output logic        err
);

  logic [31:0] imm;
  logic        i_fits;
  logic        b_fits;
  logic        j_fits;

  assign imm = fields.imm;

  // Sign-extension checks: upper bits must all match the format's sign bit.
  always_comb begin
    i_fits = (&imm[31:11]) | ~(|imm[31:11]);
    b_fits = (&imm[31:12]) | ~(|imm[31:12]);
    j_fits = (&imm[31:20]) | ~(|imm[31:20]);
  end

  // Field placement per format; truncated immediate bits are packed even on error.
  always_comb begin
    insn = '0;
    err  = 1'b0;
    case (fields.fmt)
      FMT_R: begin
        insn = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                fields.rd, fields.opcode};
      end
      FMT_I: begin
        insn = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err  = ~i_fits;
      end
      FMT_S: begin
        insn = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0],
                fields.opcode};
        err  = ~i_fits;
      end
      FMT_B: begin
        insn = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                imm[4:1], imm[11], fields.opcode};
        err  = ~b_fits | imm[0];
      end
      FMT_U: begin
        insn = {imm[31:12], fields.rd, fields.opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        insn = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd,
                fields.opcode};
        err  = ~j_fits | imm[0];
      end
      default: begin
        insn = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// Two-stage elastic RV32I instruction encoder with valid/ready on both sides.
// Optional feature macro: INSN_ENCODER_ERRCNT_EN adds err_cnt_o, a saturating
// count of output transfers that carried err_o=1.
module insn_encoder
  import insn_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [2:0]          fmt_i,
  input  logic [6:0]          opcode_i,
  input  logic [4:0]          rd_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  input  logic [DWIDTH-1:0]   imm_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DWIDTH-1:0]   insn_o,
`ifdef INSN_ENCODER_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_cnt_o,
`endif
  output logic                err_o
);

  s1_fields_t        s1_q;
  logic              s1_valid;
  logic              s2_valid;
  logic [DWIDTH-1:0] insn_q;
  logic              err_q;
  logic [31:0]       pack_insn;
  logic              pack_err;
  logic              s2_load;
  logic              in_fire;
  logic              s1_adv;

  // Ready derives only from stage occupancy and out_ready_i, never in_valid_i.
  assign s2_load    = ~s2_valid | out_ready_i;
  assign s1_adv     = s1_valid & s2_load;
  assign in_ready_o = ~s1_valid | s2_load;
  assign in_fire    = in_valid_i & in_ready_o;

  insn_pack u_pack (
    .fields (s1_q),
    .insn   (pack_insn),
    .err    (pack_err)
  );

  // Stage 1: capture raw fields on input transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_q     <= '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i,
                      rs2: rs2_i, funct3: funct3_i, funct7: funct7_i,
                      imm: imm_i};
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: register the packed word; holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      insn_q   <= '0;
      err_q    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        insn_q <= pack_insn;
        err_q  <= pack_err;
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign insn_o      = insn_q;
  assign err_o       = err_q;

`ifdef INSN_ENCODER_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  // Saturating count of errored output transfers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (s2_valid && out_ready_i && err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed vectors, boundaries,
// backpressure, async reset and randomized traffic against a range-based model.
module tb_insn_encoder;
  import insn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready_o;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid_o;
  logic        out_ready;
  logic [31:0] insn_o;
  logic        err_o;
`ifdef INSN_ENCODER_ERRCNT_EN
  logic [1:0]  err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];
  logic [32:0] cur_exp;
  logic        last_acc, last_in_ready, last_ov;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  insn_encoder #(.DWIDTH(32), .ERRCNT_W(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .fmt_i       (fmt),
    .opcode_i    (opcode),
    .rd_i        (rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .imm_i       (imm),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .insn_o      (insn_o),
`ifdef INSN_ENCODER_ERRCNT_EN
    .err_cnt_o   (err_cnt),
`endif
    .err_o       (err_o)
  );

  // Reference: representability as numeric ranges, packing as shifts/masks.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] v);
    logic [31:0] w;
    logic        e;
    int          si;
    si = v;
    w  = '0;
    e  = 1'b0;
    case (f)
      3'd0: w = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
                (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
      3'd1: begin
        w = ((v & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) |
            (32'(d) << 7) | 32'(op);
        e = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        w = (((v >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
            (32'(f3) << 12) | ((v & 32'h1F) << 7) | 32'(op);
        e = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        w = (((v >> 12) & 1) << 31) | (((v >> 5) & 32'h3F) << 25) |
            (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) |
            (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 1) << 7) | 32'(op);
        e = (si < -4096) || (si > 4095) || ((v % 2) != 0);
      end
      3'd4: begin
        w = (v & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
        e = (v % 4096) != 0;
      end
      3'd5: begin
        w = (((v >> 20) & 1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
            (((v >> 11) & 1) << 20) | (((v >> 12) & 32'hFF) << 12) |
            (32'(d) << 7) | 32'(op);
        e = (si < -(1 << 20)) || (si >= (1 << 20)) || ((v % 2) != 0);
      end
      default: begin
        w = '0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  function automatic logic [31:0] rnd_imm();
    logic [31:0] edges[12];
    int          v;
    edges = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE, 32'h1000,
              32'hFFFFF000, 32'hFFFFEFFF, 32'hFFFFE, 32'h100000, 32'hFFF00000,
              32'hFFEFFFFE};
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: begin v = int'($urandom_range(0, 10000)) - 5000; return v; end
      2: begin v = (1 << 20) + int'($urandom_range(0, 8)) - 4;
               return ($urandom_range(0, 1) != 0) ? -v : v; end
      3: return $urandom & 32'hFFFFF000;
      default: return edges[$urandom_range(0, 11)];
    endcase
  endfunction

  task automatic check_out();
    logic [32:0] e;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL unexpected_output got insn=%h err=%b, required none", insn_o, err_o);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      assert ({err_o, insn_o} === e) else begin
        n_fail++;
        $error("FAIL output got insn=%h err=%b, required insn=%h err=%b",
               insn_o, err_o, e[31:0], e[32]);
      end
    end
  endtask

  // One clock: sample at the falling edge, account for both handshakes.
  task automatic tick();
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    @(negedge clk);
    last_in_ready = in_ready_o;
    last_ov       = out_valid_o;
    last_acc      = in_valid && in_ready_o;
    if (out_valid_o && out_ready) check_out();
    if (last_acc) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] v,
                      input logic [32:0] e, output int waited);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
    imm = v; cur_exp = e; in_valid = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!last_acc && waited < 50);
    n_tests++;
    assert (last_acc === 1'b1) else begin
      n_fail++;
      $error("FAIL accept_timeout got in_ready=%b, required 1", last_in_ready);
    end
  endtask

  task automatic drain();
    int k;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %h, required %h", tag, got, want);
    end
  endtask

  initial begin
    int w;
    logic [2:0]  rf;
    logic [6:0]  rop, rf7;
    logic [4:0]  rrd, rr1, rr2;
    logic [2:0]  rf3;
    logic [31:0] rim;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0;
    funct7 = '0; imm = '0; cur_exp = '0;
    #1;
    chk("reset_out_valid", {32'b0, out_valid_o}, 33'd0);
    chk("reset_insn_err", {err_o, insn_o}, 33'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", {32'b0, in_ready_o}, 33'd1);

    // addi x1, x2, -5 with latency check
    send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB, {1'b0, 32'hFFB10093}, w);
    in_valid = 1'b0;
    tick();
    chk("latency_c1", {32'b0, last_ov}, 33'd0);
    tick();
    chk("latency_c2", {32'b0, last_ov}, 33'd1);
    drain();

    // Back-to-back stream, one accept per cycle
    send(3'd2, STORE, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h8, {1'b0, 32'h00512423}, w);
    chk("stream_s_rate", 33'(w), 33'd1);
    send(3'd3, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, {1'b0, 32'hFE208EE3}, w);
    chk("stream_b_rate", 33'(w), 33'd1);
    send(3'd5, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, {1'b0, 32'h001000EF}, w);
    chk("stream_j_rate", 33'(w), 33'd1);
    send(3'd4, LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, {1'b0, 32'h123450B7}, w);
    chk("stream_u_rate", 33'(w), 33'd1);
    drain();

    // Error boundaries
    send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h800, {1'b1, 32'h80010093}, w);
    send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h7FF, {1'b0, 32'h7FF10093}, w);
    send(3'd3, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h3, {1'b1, 32'h00208163}, w);
    send(3'd4, LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, {1'b1, 32'h123450B7}, w);
    send(3'd7, OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, {1'b1, 32'h0}, w);
    drain();

    // Backpressure: two held, third stalls, head output stays put
    out_ready = 1'b0;
    send(3'd0, OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h0, model(3'd0, OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h0), w);
    send(3'd1, LOAD, 5'd6, 5'd7, 5'd0, 3'd2, 7'd0, 32'h10, model(3'd1, LOAD, 5'd6, 5'd7, 5'd0, 3'd2, 7'd0, 32'h10), w);
    fmt = 3'd4; opcode = AUIPC; rd = 5'd9; imm = 32'hABCDE000;
    cur_exp = model(3'd4, AUIPC, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    in_valid = 1'b1;
    tick();
    chk("bp_in_ready_low", {32'b0, last_in_ready}, 33'd0);
    tick();
    chk("bp_head_stable", {err_o, insn_o}, exp_q[0]);
    tick();
    chk("bp_head_stable2", {err_o, insn_o}, exp_q[0]);
    chk("bp_in_ready_still_low", {32'b0, in_ready_o}, 33'd0);
    out_ready = 1'b1;
    w = 0;
    do begin tick(); w++; end while (!last_acc && w < 10);
    chk("bp_third_accepted", {32'b0, last_acc}, 33'd1);
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rf = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rop = 7'($urandom); rrd = 5'($urandom); rr1 = 5'($urandom); rr2 = 5'($urandom);
      rf3 = 3'($urandom); rf7 = 7'($urandom); rim = rnd_imm();
      rand_ready = 1'b1;
      send(rf, rop, rrd, rr1, rr2, rf3, rf7, rim, model(rf, rop, rrd, rr1, rr2, rf3, rf7, rim), w);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    drain();

    // Reset with two items in flight
    out_ready = 1'b0;
    send(3'd1, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h1, model(3'd1, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h1), w);
    send(3'd1, OP_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'h2, model(3'd1, OP_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'h2), w);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {32'b0, out_valid_o}, 33'd0);
    chk("async_rst_insn_err", {err_o, insn_o}, 33'd0);
    chk("async_rst_in_ready", {32'b0, in_ready_o}, 33'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("no_stale_output", {32'b0, last_ov}, 33'd0);

`ifdef INSN_ENCODER_ERRCNT_EN
    chk("errcnt_reset", 33'(err_cnt), 33'd0);
    send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h800, {1'b1, 32'h80010093}, w);
    send(3'd7, OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, {1'b1, 32'h0}, w);
    drain();
    chk("errcnt_two", 33'(err_cnt), 33'd2);
    send(3'd3, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h3, {1'b1, 32'h00208163}, w);
    send(3'd1, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h7FF, {1'b0, 32'h7FF10093}, w);
    drain();
    chk("errcnt_three", 33'(err_cnt), 33'd3);
    send(3'd4, LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, {1'b1, 32'h123450B7}, w);
    send(3'd6, OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, {1'b1, 32'h0}, w);
    drain();
    chk("errcnt_saturated", 33'(err_cnt), 33'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
